// File: rtl/ext_bus_arbiter_if.sv
// ext_bus_if: one External-bus style request/response channel.
//   bus_enable  request strobe, held by the requester until acknowledge
//   address     ADDR_W-bit target address
//   byte_enable DATA_W/8 byte lanes
//   rw          1 = read, 0 = write
//   write_data  DATA_W-bit write payload
//   read_data   DATA_W-bit read payload returned with acknowledge
//   acknowledge one-cycle completion pulse
//   irq         interrupt line (responder to requester)
// Modports:
//   master - the side issuing requests (drives bus_enable..write_data)
//   slave  - the side answering requests (drives read_data, acknowledge, irq)
interface ext_bus_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 16
);
  localparam int BE_W = DATA_W / 8;

  logic              bus_enable;
  logic [ADDR_W-1:0] address;
  logic [BE_W-1:0]   byte_enable;
  logic              rw;
  logic [DATA_W-1:0] write_data;
  logic [DATA_W-1:0] read_data;
  logic              acknowledge;
  logic              irq;

  modport master (
    output bus_enable, address, byte_enable, rw, write_data,
    input  read_data, acknowledge, irq
  );

  modport slave (
    input  bus_enable, address, byte_enable, rw, write_data,
    output read_data, acknowledge, irq
  );
endinterface

// File: rtl/ext_bus_arbiter.sv
// ext_bus_arbiter: round-robin arbiter letting two External-bus requesters
// share one slave. One transaction at a time; the grant is held until the
// slave acknowledges, then a one-cycle acknowledge is returned to the winner.
// The slave interrupt is registered and fanned out to both requesters.
// Ports:
//   clk_clk       single rising-edge clock
//   reset         synchronous active-high reset
//   m0, m1        requester channels (ext_bus_if.slave)
//   s             shared slave channel (ext_bus_if.master)
//   grant         index of current / last granted requester
//   timeout_flag  sticky access-timeout indicator
// Optional feature: define ARB_TIMEOUT_EN to force completion of an access
// after TIMEOUT_CYCLES cycles without slave acknowledge, returning
// TIMEOUT_RDATA and setting timeout_flag. Without it timeout_flag is 0.
module ext_bus_arbiter #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 16
`ifdef ARB_TIMEOUT_EN
  ,
  parameter int                TIMEOUT_CYCLES = 255,
  parameter logic [DATA_W-1:0] TIMEOUT_RDATA  = DATA_W'(16'hDEAD)
`endif
) (
  input  logic      clk_clk,
  input  logic      reset,
  ext_bus_if.slave  m0,
  ext_bus_if.slave  m1,
  ext_bus_if.master s,
  output logic      grant,
  output logic      timeout_flag
);
  localparam int BE_W = DATA_W / 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t            state_r, state_s;
  logic              winner_s, start_s, finish_s, expire_s;
  logic [DATA_W-1:0] cap_data_s;

  logic              grant_r, last_grant_r;
  logic              bus_en_r, rw_r;
  logic [ADDR_W-1:0] address_r;
  logic [BE_W-1:0]   byte_en_r;
  logic [DATA_W-1:0] wdata_r;
  logic [DATA_W-1:0] m0_rdata_r, m1_rdata_r;
  logic              m0_ack_r, m1_ack_r, irq_r;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_cnt_r;
  logic             timeout_flag_r, timeout_hit_s;

  assign expire_s      = (tmo_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));
  // Slave acknowledge on the terminal cycle takes precedence over the timeout.
  assign timeout_hit_s = (state_r == ST_ACCESS) && !s.acknowledge && expire_s;
  assign timeout_flag  = timeout_flag_r;

  // Access-cycle counter, restarted on every ACCESS entry.
  always_ff @(posedge clk_clk) begin
    if (reset) begin
      tmo_cnt_r <= '0;
    end else if (start_s) begin
      tmo_cnt_r <= '0;
    end else if (state_r == ST_ACCESS) begin
      tmo_cnt_r <= tmo_cnt_r + CNT_W'(1);
    end else begin
      tmo_cnt_r <= tmo_cnt_r;
    end
  end

  // Sticky timeout indicator, cleared only by reset.
  always_ff @(posedge clk_clk) begin
    if (reset) begin
      timeout_flag_r <= 1'b0;
    end else if (timeout_hit_s) begin
      timeout_flag_r <= 1'b1;
    end else begin
      timeout_flag_r <= timeout_flag_r;
    end
  end

  // Read data returned to the requester: slave data or the timeout pattern.
  always_comb begin
    cap_data_s = s.read_data;
    if (timeout_hit_s) begin
      cap_data_s = TIMEOUT_RDATA;
    end else begin
      cap_data_s = s.read_data;
    end
  end
`else
  assign expire_s     = 1'b0;
  assign timeout_flag = 1'b0;

  // Read data returned to the requester comes straight from the slave.
  always_comb begin
    cap_data_s = s.read_data;
  end
`endif

  // FSM state register.
  always_ff @(posedge clk_clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state, arbitration and transaction start/finish strobes.
  always_comb begin
    state_s  = state_r;
    winner_s = last_grant_r;
    start_s  = 1'b0;
    finish_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (m0.bus_enable && m1.bus_enable) begin
          winner_s = ~last_grant_r;
          start_s  = 1'b1;
          state_s  = ST_ACCESS;
        end else if (m0.bus_enable) begin
          winner_s = 1'b0;
          start_s  = 1'b1;
          state_s  = ST_ACCESS;
        end else if (m1.bus_enable) begin
          winner_s = 1'b1;
          start_s  = 1'b1;
          state_s  = ST_ACCESS;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (s.acknowledge || expire_s) begin
          finish_s = 1'b1;
          state_s  = ST_DONE;
        end else begin
          state_s = ST_ACCESS;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Registered slave request, grant, acknowledges and read-data holding.
  always_ff @(posedge clk_clk) begin
    if (reset) begin
      grant_r      <= 1'b0;
      last_grant_r <= 1'b1;
      bus_en_r     <= 1'b0;
      rw_r         <= 1'b0;
      address_r    <= '0;
      byte_en_r    <= '0;
      wdata_r      <= '0;
      m0_rdata_r   <= '0;
      m1_rdata_r   <= '0;
      m0_ack_r     <= 1'b0;
      m1_ack_r     <= 1'b0;
      irq_r        <= 1'b0;
    end else begin
      irq_r    <= s.irq;
      m0_ack_r <= finish_s && !grant_r;
      m1_ack_r <= finish_s && grant_r;
      if (start_s) begin
        // Fields are frozen here; requester changes during ACCESS are ignored.
        grant_r      <= winner_s;
        last_grant_r <= winner_s;
        bus_en_r     <= 1'b1;
        rw_r         <= winner_s ? m1.rw          : m0.rw;
        address_r    <= winner_s ? m1.address     : m0.address;
        byte_en_r    <= winner_s ? m1.byte_enable : m0.byte_enable;
        wdata_r      <= winner_s ? m1.write_data  : m0.write_data;
      end else if (finish_s) begin
        bus_en_r <= 1'b0;
      end else begin
        bus_en_r <= bus_en_r;
      end
      // Writes leave the requester's read data untouched.
      if (finish_s && rw_r && !grant_r) begin
        m0_rdata_r <= cap_data_s;
      end else if (finish_s && rw_r && grant_r) begin
        m1_rdata_r <= cap_data_s;
      end else begin
        m0_rdata_r <= m0_rdata_r;
        m1_rdata_r <= m1_rdata_r;
      end
    end
  end

  assign grant          = grant_r;
  assign s.bus_enable   = bus_en_r;
  assign s.address      = address_r;
  assign s.byte_enable  = byte_en_r;
  assign s.rw           = rw_r;
  assign s.write_data   = wdata_r;
  assign m0.read_data   = m0_rdata_r;
  assign m0.acknowledge = m0_ack_r;
  assign m0.irq         = irq_r;
  assign m1.read_data   = m1_rdata_r;
  assign m1.acknowledge = m1_ack_r;
  assign m1.irq         = irq_r;
endmodule
